usp_cfg_ext_vsec_responder: RTL and testbench
=============================================

Name: usp_cfg_ext_vsec_responder

Overview:
- Responder side of the USP configuration extended interface.
- The PCIe IP forwards a config read that targets the user extended space. This block returns the read data with a single-cycle valid pulse after a fixed latency.
- It implements one Vendor-Specific Extended Capability (VSEC) for function 0. The VSEC exposes the snooped switch bus numbers, two scratch registers and access counters, so host software can check switch routing state.

Parameters:
VSEC_BASE, 10'h3A0, DWORD register number of the VSEC header (byte 0xE80)
NEXT_PTR, 12'h000, next-capability pointer in the extended capability header
VSEC_ID, 16'h5357, vendor VSEC ID
VSEC_REV, 4'h1, VSEC revision
RD_LATENCY, 2, cycles from read accept to data-valid pulse; legal range 1..15

Ports:
usp_user_clk  in  1  USP user clock
usp_user_reset  in  1  asynchronous active-high reset
usp_cfg_ext_read_received  in  1  single-cycle read request strobe
usp_cfg_ext_write_received  in  1  single-cycle write request strobe
usp_cfg_ext_register_number  in  10  DWORD register number
usp_cfg_ext_function_number  in  8  function number
usp_cfg_ext_write_data  in  32  write data
usp_cfg_ext_write_byte_enable  in  4  write byte enables
usp_pri_bus  in  8  snooped primary bus number
usp_sec_bus  in  8  snooped secondary bus number
usp_sub_bus  in  8  snooped subordinate bus number
all_bus_numbers_ready  in  1  all three bus numbers captured
usp_cfg_ext_read_data  out  32  read response data
usp_cfg_ext_read_data_valid  out  1  single-cycle response strobe
rd_overrun  out  1  sticky: a read arrived while a response was pending

Behaviour:
- Reset: usp_user_reset is asynchronous, active-high. All outputs 0, all registers 0, FSM in IDLE. Reset mid-response aborts it; no valid pulse follows.
- Hit rule: function_number==0 and VSEC_BASE <= register_number <= VSEC_BASE+5. Offset = register_number - VSEC_BASE.
- Register map (RO writes ignored):
  - +0 RO: {NEXT_PTR, 4'h1, 16'h000B}
  - +1 RO: {12'h018, VSEC_REV, VSEC_ID}
  - +2 RO: {7'b0, all_bus_numbers_ready, sub, sec, pri}
  - +3 RW: scratch0, per-byte enables
  - +4 RW: scratch1, per-byte enables
  - +5: {wr_cnt[15:0], rd_cnt[15:0]}; any write (any byte enables, including 0) clears both counters
- Non-hit reads: accepted and answered with 32'h0 at the normal latency; the IP always requires a response.
- FSM has two states:
  - IDLE: on read_received, snapshot the read mux into the data register (values as of that clock edge, i.e. pre-write if a write lands the same cycle), load lat_cnt = RD_LATENCY-1, go to WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt==0, drive read_data_valid=1 for exactly one cycle with read_data = snapshot, then return to IDLE.
  - RD_LATENCY=1: valid fires the cycle after accept. Back-to-back reads are therefore spaced at least RD_LATENCY+1 cycles apart.
- Overrun: read_received while in WAIT, or in the cycle valid is high, is dropped; set rd_overrun (sticky until reset). The pending response is unaffected.
- read_data is 0 whenever read_data_valid is 0.
- Writes are independent of the FSM: applied at the clock edge they are received, in any state.
- Counters:
  - rd_cnt increments on each accepted read that hits the VSEC.
  - wr_cnt increments on each write to +3 or +4 that has at least one byte enable set.
  - Both saturate at 16'hFFFF.
  - A clear and an increment in the same cycle: clear wins.
  - The read of +5 itself counts after its snapshot, so the returned value excludes that read.

Test Plan:
- Reset release, read +0 (reg 0x3A0, fn 0), RD_LATENCY=2 -> valid 2 cycles after strobe; data 32'h0001000B; valid 1 cycle wide.
- pri=0x01, sec=0x02, sub=0x05, ready=1; read 0x3A2 -> data 32'h01050201; drop ready to 0 -> data 32'h00050201.
- Write 0x3A3, data 32'hAABBCCDD, BE=4'b0101 -> readback 32'h00BB00DD; read 0x3A5 -> wr_cnt=1, rd_cnt=1 (excludes the current read), returned 32'h00010001.
- Read fn 1 reg 0x3A0, and fn 0 reg 0x3A6 -> both return 32'h0 with valid at normal latency; rd_cnt unchanged.
- Second read_received one cycle after the first -> single valid pulse with the first read's data; rd_overrun=1 and stays 1.
- Assert reset while in WAIT -> no valid pulse; scratch and counters read back 0 afterwards.

Source files
------------

// File: rtl/usp_cfg_ext_vsec_responder.sv
// rtl/usp_cfg_ext_vsec_responder.sv - USP config-extended VSEC read/write responder
//
// Purpose: answers config-extended reads forwarded by the PCIe IP with a
// one-cycle valid pulse RD_LATENCY cycles after the read strobe. It implements
// one VSEC on function 0 that exposes the snooped switch bus numbers, two
// scratch registers and read/write access counters. Reads that miss the VSEC
// return zero, because the IP always expects a response.
//
// Ports:
//   usp_user_clk, usp_user_reset      clock, asynchronous active-high reset
//   usp_cfg_ext_read_received         read request strobe
//   usp_cfg_ext_write_received        write request strobe
//   usp_cfg_ext_register_number       DWORD register number
//   usp_cfg_ext_function_number       function number
//   usp_cfg_ext_write_data/_byte_enable  write payload and byte enables
//   usp_pri/sec/sub_bus, all_bus_numbers_ready  snooped bus numbers
//   usp_cfg_ext_read_data(_valid)     read response and its strobe
//   rd_overrun                        sticky flag for a read that was dropped
module usp_cfg_ext_vsec_responder #(
   parameter logic [9:0]  VSEC_BASE  = 10'h3A0,
   parameter logic [11:0] NEXT_PTR   = 12'h000,
   parameter logic [15:0] VSEC_ID    = 16'h5357,
   parameter logic [3:0]  VSEC_REV   = 4'h1,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic        usp_user_clk,
   input  logic        usp_user_reset,
   input  logic        usp_cfg_ext_read_received,
   input  logic        usp_cfg_ext_write_received,
   input  logic [9:0]  usp_cfg_ext_register_number,
   input  logic [7:0]  usp_cfg_ext_function_number,
   input  logic [31:0] usp_cfg_ext_write_data,
   input  logic [3:0]  usp_cfg_ext_write_byte_enable,
   input  logic [7:0]  usp_pri_bus,
   input  logic [7:0]  usp_sec_bus,
   input  logic [7:0]  usp_sub_bus,
   input  logic        all_bus_numbers_ready,
   output logic [31:0] usp_cfg_ext_read_data,
   output logic        usp_cfg_ext_read_data_valid,
   output logic        rd_overrun
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  lat_q, lat_d;
   logic [31:0] data_q, data_d;
   logic [31:0] scratch0_q, scratch0_d;
   logic [31:0] scratch1_q, scratch1_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic        overrun_q, overrun_d;

   logic [9:0]  offset;
   logic        hit;
   logic        rd_accept;
   logic        wr_scratch;
   logic        wr_clear;
   logic [31:0] rd_mux;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

   assign offset = usp_cfg_ext_register_number - VSEC_BASE;
   assign hit    = (usp_cfg_ext_function_number == 8'd0) &&
                   (usp_cfg_ext_register_number >= VSEC_BASE) &&
                   (usp_cfg_ext_register_number <= VSEC_BASE + 10'd5);

   // Reads are only taken in IDLE; anything arriving while a response is
   // pending (including its valid cycle) is dropped and flagged.
   assign rd_accept  = usp_cfg_ext_read_received && (state_q == S_IDLE);
   assign wr_scratch = usp_cfg_ext_write_received && hit &&
                       ((offset == 10'd3) || (offset == 10'd4)) &&
                       (|usp_cfg_ext_write_byte_enable);
   assign wr_clear   = usp_cfg_ext_write_received && hit && (offset == 10'd5);

   // Read mux uses current register values, so a same-cycle write is not seen.
   always_comb begin
      rd_mux = 32'h0;
      if (hit) begin
         case (offset)
            10'd0:   rd_mux = {NEXT_PTR, 4'h1, 16'h000B};
            10'd1:   rd_mux = {12'h018, VSEC_REV, VSEC_ID};
            10'd2:   rd_mux = {7'b0, all_bus_numbers_ready, usp_sub_bus,
                               usp_sec_bus, usp_pri_bus};
            10'd3:   rd_mux = scratch0_q;
            10'd4:   rd_mux = scratch1_q;
            10'd5:   rd_mux = {wr_cnt_q, rd_cnt_q};
            default: rd_mux = 32'h0;
         endcase
      end
   end

   // FSM: state register
   always_ff @(posedge usp_user_clk or posedge usp_user_reset) begin
      if (usp_user_reset) begin
         state_q <= S_IDLE;
         lat_q   <= 4'd0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (usp_cfg_ext_read_received) begin
               data_d  = rd_mux;
               lat_d   = 4'(RD_LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_q == 4'd0) state_d = S_IDLE;
            else               lat_d   = lat_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      usp_cfg_ext_read_data_valid = (state_q == S_WAIT) && (lat_q == 4'd0);
      usp_cfg_ext_read_data       = usp_cfg_ext_read_data_valid ? data_q : 32'h0;
   end

   assign rd_overrun = overrun_q;

   // Register file, counters and overrun flag; writes land in any FSM state.
   always_comb begin
      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      overrun_d  = overrun_q | (usp_cfg_ext_read_received && (state_q == S_WAIT));
      if (usp_cfg_ext_write_received && hit && (offset == 10'd3))
         scratch0_d = merge_bytes(scratch0_q, usp_cfg_ext_write_data,
                                  usp_cfg_ext_write_byte_enable);
      if (usp_cfg_ext_write_received && hit && (offset == 10'd4))
         scratch1_d = merge_bytes(scratch1_q, usp_cfg_ext_write_data,
                                  usp_cfg_ext_write_byte_enable);
      if (rd_accept && hit && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
      if (wr_scratch && (wr_cnt_q != 16'hFFFF))       wr_cnt_d = wr_cnt_q + 16'd1;
      // Clear takes priority over a same-cycle increment.
      if (wr_clear) begin
         rd_cnt_d = 16'h0;
         wr_cnt_d = 16'h0;
      end
   end

   always_ff @(posedge usp_user_clk or posedge usp_user_reset) begin
      if (usp_user_reset) begin
         scratch0_q <= 32'h0;
         scratch1_q <= 32'h0;
         rd_cnt_q   <= 16'h0;
         wr_cnt_q   <= 16'h0;
         overrun_q  <= 1'b0;
      end else begin
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_usp_cfg_ext_vsec_responder.sv
// tb/tb_usp_cfg_ext_vsec_responder.sv - self-checking bench for usp_cfg_ext_vsec_responder
module tb_usp_cfg_ext_vsec_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_rx = 1'b0;
   logic        wr_rx = 1'b0;
   logic [9:0]  reg_num = 10'h0;
   logic [7:0]  fn_num = 8'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  wbe = 4'h0;
   logic [7:0]  pri = 8'h0, sec = 8'h0, sub = 8'h0;
   logic        ready = 1'b0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        overrun;

   int total = 0;
   int passed = 0;
   logic [31:0] exp_q[$];
   int rd_cnt_m = 0;
   int wr_cnt_m = 0;

   always #5 clk = ~clk;

   usp_cfg_ext_vsec_responder #(
      .VSEC_BASE(10'h3A0), .NEXT_PTR(12'h000), .VSEC_ID(16'h5357),
      .VSEC_REV(4'h1), .RD_LATENCY(LAT)
   ) dut (
      .usp_user_clk                  (clk),
      .usp_user_reset                (rst),
      .usp_cfg_ext_read_received     (rd_rx),
      .usp_cfg_ext_write_received    (wr_rx),
      .usp_cfg_ext_register_number   (reg_num),
      .usp_cfg_ext_function_number   (fn_num),
      .usp_cfg_ext_write_data        (wdata),
      .usp_cfg_ext_write_byte_enable (wbe),
      .usp_pri_bus                   (pri),
      .usp_sec_bus                   (sec),
      .usp_sub_bus                   (sub),
      .all_bus_numbers_ready         (ready),
      .usp_cfg_ext_read_data         (rdata),
      .usp_cfg_ext_read_data_valid   (rvalid),
      .rd_overrun                    (overrun)
   );

   // Issue one read, push its expected data, then wait for the response and
   // check latency, data and pulse width against the scoreboard.
   task automatic do_read(input string name, input logic [9:0] r,
                          input logic [7:0] f, input logic [31:0] exp);
      int cyc;
      logic [31:0] e;
      @(negedge clk);
      rd_rx = 1'b1; reg_num = r; fn_num = f;
      exp_q.push_back(exp);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) rd_rx = 1'b0;
      end while (!rvalid && cyc < 20);
      e = exp_q.pop_front();
      total++;
      if (rvalid !== 1'b1) $display("FAIL %s timeout: valid=%b required 1", name, rvalid);
      else passed++;
      total++;
      if (cyc != LAT) $display("FAIL %s latency: got %0d required %0d", name, cyc, LAT);
      else passed++;
      total++;
      if (rdata !== e) $display("FAIL %s data: got %h required %h", name, rdata, e);
      else passed++;
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || rdata !== 32'h0)
         $display("FAIL %s width: valid=%b data=%h required 0/0", name, rvalid, rdata);
      else passed++;
   endtask

   task automatic do_write(input logic [9:0] r, input logic [7:0] f,
                           input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_rx = 1'b1; reg_num = r; fn_num = f; wdata = d; wbe = be;
      @(negedge clk);
      wr_rx = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || rdata !== 32'h0 || overrun !== 1'b0)
         $display("FAIL reset_outputs: valid=%b data=%h ovr=%b required 0/0/0",
                  rvalid, rdata, overrun);
      else passed++;
   endtask

   task automatic test_header;
      do_read("hdr0", 10'h3A0, 8'd0, 32'h0001000B); rd_cnt_m++;
      do_read("hdr1", 10'h3A1, 8'd0, 32'h01815357); rd_cnt_m++;
   endtask

   task automatic test_bus;
      pri = 8'h01; sec = 8'h02; sub = 8'h05; ready = 1'b1;
      do_read("bus_ready", 10'h3A2, 8'd0, 32'h01050201); rd_cnt_m++;
      ready = 1'b0;
      do_read("bus_notready", 10'h3A2, 8'd0, 32'h00050201); rd_cnt_m++;
   endtask

   task automatic test_scratch_counters;
      do_write(10'h3A5, 8'd0, 32'h0, 4'b0000);
      rd_cnt_m = 0; wr_cnt_m = 0;
      do_write(10'h3A3, 8'd0, 32'hAABBCCDD, 4'b0101); wr_cnt_m++;
      do_read("scratch0_be", 10'h3A3, 8'd0, 32'h00BB00DD); rd_cnt_m++;
      do_read("cnt_first", 10'h3A5, 8'd0, {wr_cnt_m[15:0], rd_cnt_m[15:0]}); rd_cnt_m++;
      do_write(10'h3A4, 8'd0, 32'hFFFFFFFF, 4'b0000);
      do_write(10'h3A4, 8'd0, 32'h12345678, 4'b1111); wr_cnt_m++;
      do_write(10'h3A0, 8'd0, 32'hDEADBEEF, 4'b1111);
      do_read("scratch1", 10'h3A4, 8'd0, 32'h12345678); rd_cnt_m++;
      do_read("ro_hdr", 10'h3A0, 8'd0, 32'h0001000B); rd_cnt_m++;
      do_read("cnt_second", 10'h3A5, 8'd0, {wr_cnt_m[15:0], rd_cnt_m[15:0]}); rd_cnt_m++;
   endtask

   task automatic test_miss;
      do_read("miss_fn1", 10'h3A0, 8'd1, 32'h0);
      do_read("miss_reg", 10'h3A6, 8'd0, 32'h0);
      do_read("miss_below", 10'h39F, 8'd0, 32'h0);
      do_read("cnt_after_miss", 10'h3A5, 8'd0, {wr_cnt_m[15:0], rd_cnt_m[15:0]}); rd_cnt_m++;
   endtask

   task automatic test_back_to_back;
      int extra;
      @(negedge clk);
      rd_rx = 1'b1; reg_num = 10'h3A0; fn_num = 8'd0;
      exp_q.push_back(32'h0001000B);
      @(negedge clk);
      reg_num = 10'h3A1;
      @(negedge clk);
      rd_rx = 1'b0;
      total++;
      if (rvalid !== 1'b1 || exp_q.size() == 0)
         $display("FAIL b2b_valid: valid=%b required 1", rvalid);
      else passed++;
      if (exp_q.size() != 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         total++;
         if (rdata !== e) $display("FAIL b2b_data: got %h required %h", rdata, e);
         else passed++;
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid) extra++;
      end
      total++;
      if (extra != 0) $display("FAIL b2b_single_pulse: extra pulses %0d required 0", extra);
      else passed++;
      total++;
      if (overrun !== 1'b1) $display("FAIL overrun_set: got %b required 1", overrun);
      else passed++;
      do_read("after_overrun", 10'h3A1, 8'd0, 32'h01815357);
      total++;
      if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b required 1", overrun);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int pulses;
      do_write(10'h3A3, 8'd0, 32'h11223344, 4'b1111);
      @(negedge clk);
      rd_rx = 1'b1; reg_num = 10'h3A3; fn_num = 8'd0;
      @(negedge clk);
      rd_rx = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (rvalid) pulses++;
      end
      total++;
      if (pulses != 0) $display("FAIL reset_abort: pulses %0d required 0", pulses);
      else passed++;
      total++;
      if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b required 0", overrun);
      else passed++;
      do_read("reset_cnt", 10'h3A5, 8'd0, 32'h0);
      do_read("reset_scratch0", 10'h3A3, 8'd0, 32'h0);
      do_read("reset_scratch1", 10'h3A4, 8'd0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_header();
      test_bus();
      test_scratch_counters();
      test_miss();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
